// File: rtl/mem_wide_lane_sync.sv
// mem_wide_lane_sync
//   Splits one wide memory request into NrPorts narrow lane requests and
//   merges the per-lane responses back into a single wide response.
//   Lanes that are not granted in the accept cycle are held and re-issued
//   until granted. Responses may arrive skewed across lanes; each lane queues
//   its responses in a small FIFO. The wide response fires once every lane
//   has one available. The number of wide transactions in flight is capped
//   at MaxOutstanding, so the lane FIFOs can never overflow.
//
// Ports
//   clk_i, rst_ni         clock, synchronous active-low reset
//   wide_req_*            wide request (valid/ready, addr, wen, wdata, be)
//   wide_rsp_*            wide response (valid/ready, reassembled rdata)
//   lane_req_*            per-lane narrow requests (flattened, lane i at slice i)
//   lane_rsp_*            per-lane narrow responses (flattened)
//   busy_o                transaction in flight or lanes still pending
module mem_wide_lane_sync #(
  parameter int unsigned NarrowDataWidth = 32,
  parameter int unsigned WideDataWidth   = 512,
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned MaxOutstanding  = 4,
  parameter int unsigned NrPorts         = WideDataWidth / NarrowDataWidth,
  parameter int unsigned NarrowBeWidth   = NarrowDataWidth / 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 wide_req_valid_i,
  output logic                                 wide_req_ready_o,
  input  logic [AddrWidth-1:0]                 wide_req_addr_i,
  input  logic                                 wide_req_wen_i,
  input  logic [WideDataWidth-1:0]             wide_req_wdata_i,
  input  logic [WideDataWidth/8-1:0]           wide_req_be_i,
  output logic                                 wide_rsp_valid_o,
  input  logic                                 wide_rsp_ready_i,
  output logic [WideDataWidth-1:0]             wide_rsp_rdata_o,
  output logic [NrPorts-1:0]                   lane_req_valid_o,
  input  logic [NrPorts-1:0]                   lane_req_ready_i,
  output logic [NrPorts*AddrWidth-1:0]         lane_req_addr_o,
  output logic [NrPorts-1:0]                   lane_req_wen_o,
  output logic [NrPorts*NarrowDataWidth-1:0]   lane_req_wdata_o,
  output logic [NrPorts*NarrowBeWidth-1:0]     lane_req_be_o,
  input  logic [NrPorts-1:0]                   lane_rsp_valid_i,
  output logic [NrPorts-1:0]                   lane_rsp_ready_o,
  input  logic [NrPorts*NarrowDataWidth-1:0]   lane_rsp_rdata_i,
  output logic                                 busy_o
);

  localparam int unsigned WideBeWidth = WideDataWidth / 8;
  localparam int unsigned CntW        = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW        = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  if ((WideDataWidth % NarrowDataWidth) != 0) begin : gen_width_check
    $error("WideDataWidth must be a multiple of NarrowDataWidth");
  end

  // state | meaning
  // IDLE  | accepting wide requests; lanes driven straight from the wide inputs
  // ISSUE | some lanes not yet granted; re-issuing them from the held request
  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                    state_q, state_d;
  logic [NrPorts-1:0]        pend_q, pend_d;
  logic                      hold_en;
  logic [AddrWidth-1:0]      addr_q;
  logic                      wen_q;
  logic [WideDataWidth-1:0]  wdata_q;
  logic [WideBeWidth-1:0]    be_q;
  logic [CntW-1:0]           cnt_q;

  logic                      credit_ok;
  logic                      req_ready;
  logic                      req_hs;
  logic                      rsp_valid;
  logic                      rsp_hs;
  logic [NrPorts-1:0]        lane_valid;
  logic [NrPorts-1:0]        fifo_full;
  logic [NrPorts-1:0]        fifo_nonempty;
  logic [NrPorts-1:0]        fifo_push;
  logic [WideDataWidth-1:0]  head_data;

  logic [AddrWidth-1:0]      src_addr;
  logic                      src_wen;
  logic [WideDataWidth-1:0]  src_wdata;
  logic [WideBeWidth-1:0]    src_be;

  assign credit_ok = cnt_q < CntW'(MaxOutstanding);
  assign req_ready = (state_q == IDLE) && credit_ok;
  assign req_hs    = wide_req_valid_i && req_ready;
  assign rsp_valid = &fifo_nonempty;
  assign rsp_hs    = rsp_valid && wide_rsp_ready_i;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    hold_en    = 1'b0;
    lane_valid = '0;
    case (state_q)
      IDLE: begin
        lane_valid = {NrPorts{wide_req_valid_i && credit_ok}};
        if (req_hs && (lane_req_ready_i != '1)) begin
          hold_en = 1'b1;
          pend_d  = ~lane_req_ready_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        lane_valid = pend_q;
        pend_d     = pend_q & ~lane_req_ready_i;
        if (pend_d == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Held request needs no reset: it is only observed while in ISSUE.
  always_ff @(posedge clk_i) begin
    if (hold_en) begin
      addr_q  <= wide_req_addr_i;
      wen_q   <= wide_req_wen_i;
      wdata_q <= wide_req_wdata_i;
      be_q    <= wide_req_be_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      case ({req_hs, rsp_hs})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign src_addr  = (state_q == ISSUE) ? addr_q  : wide_req_addr_i;
  assign src_wen   = (state_q == ISSUE) ? wen_q   : wide_req_wen_i;
  assign src_wdata = (state_q == ISSUE) ? wdata_q : wide_req_wdata_i;
  assign src_be    = (state_q == ISSUE) ? be_q    : wide_req_be_i;

  for (genvar g = 0; g < NrPorts; g++) begin : gen_lane
    logic [NarrowDataWidth-1:0] mem [MaxOutstanding];
    logic [PtrW-1:0]            rd_ptr, wr_ptr;
    logic [CntW-1:0]            fcnt;

    assign lane_req_addr_o [g*AddrWidth +: AddrWidth] =
      rst_ni ? src_addr : '0;
    assign lane_req_wen_o  [g] = rst_ni && src_wen;
    assign lane_req_wdata_o[g*NarrowDataWidth +: NarrowDataWidth] =
      rst_ni ? src_wdata[g*NarrowDataWidth +: NarrowDataWidth] : '0;
    assign lane_req_be_o   [g*NarrowBeWidth +: NarrowBeWidth] =
      rst_ni ? src_be[g*NarrowBeWidth +: NarrowBeWidth] : '0;

    assign fifo_full[g]     = fcnt == CntW'(MaxOutstanding);
    assign fifo_nonempty[g] = fcnt != '0;
    assign fifo_push[g]     = lane_rsp_valid_i[g] && !fifo_full[g];
    assign head_data[g*NarrowDataWidth +: NarrowDataWidth] = mem[rd_ptr];

    // All lanes pop together on the wide response handshake, so rsp_hs is
    // the per-lane pop.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        fcnt   <= '0;
      end else begin
        if (fifo_push[g]) begin
          wr_ptr <= (wr_ptr == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr + PtrW'(1);
        end
        if (rsp_hs) begin
          rd_ptr <= (rd_ptr == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr + PtrW'(1);
        end
        case ({fifo_push[g], rsp_hs})
          2'b10:   fcnt <= fcnt + CntW'(1);
          2'b01:   fcnt <= fcnt - CntW'(1);
          default: fcnt <= fcnt;
        endcase
      end
    end

    always_ff @(posedge clk_i) begin
      if (fifo_push[g]) begin
        mem[wr_ptr] <= lane_rsp_rdata_i[g*NarrowDataWidth +: NarrowDataWidth];
      end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(fifo_push[g] && fifo_full[g]));

    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (lane_req_valid_o[g] && !lane_req_ready_i[g]) |=>
        (!rst_ni || (lane_req_valid_o[g]
          && $stable(lane_req_addr_o[g*AddrWidth +: AddrWidth])
          && $stable(lane_req_wen_o[g])
          && $stable(lane_req_wdata_o[g*NarrowDataWidth +: NarrowDataWidth])
          && $stable(lane_req_be_o[g*NarrowBeWidth +: NarrowBeWidth]))));
  end

  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CntW'(MaxOutstanding));

  // Every output is held at zero while reset is asserted.
  assign wide_req_ready_o = rst_ni && req_ready;
  assign lane_req_valid_o = rst_ni ? lane_valid : '0;
  assign lane_rsp_ready_o = rst_ni ? ~fifo_full : '0;
  assign wide_rsp_valid_o = rst_ni && rsp_valid;
  assign wide_rsp_rdata_o = rst_ni ? head_data : '0;
  assign busy_o           = rst_ni && ((cnt_q != '0) || (state_q == ISSUE));

endmodule

// File: tb/tb_mem_wide_lane_sync.sv
module tb_mem_wide_lane_sync;
  localparam int NW = 32;
  localparam int WW = 128;
  localparam int AW = 32;
  localparam int MO = 2;
  localparam int NP = 4;
  localparam int NB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wreq_valid;
  logic            wreq_ready;
  logic [AW-1:0]   wreq_addr;
  logic            wreq_wen;
  logic [WW-1:0]   wreq_wdata;
  logic [WW/8-1:0] wreq_be;
  logic            wrsp_valid;
  logic            wrsp_ready;
  logic [WW-1:0]   wrsp_rdata;
  logic [NP-1:0]   lreq_valid;
  logic [NP-1:0]   lreq_ready;
  logic [NP*AW-1:0] lreq_addr;
  logic [NP-1:0]   lreq_wen;
  logic [NP*NW-1:0] lreq_wdata;
  logic [NP*NB-1:0] lreq_be;
  logic [NP-1:0]   lrsp_valid;
  logic [NP-1:0]   lrsp_ready;
  logic [NP*NW-1:0] lrsp_rdata;
  logic            busy;

  always #5 clk = ~clk;

  mem_wide_lane_sync #(
    .NarrowDataWidth(NW), .WideDataWidth(WW), .AddrWidth(AW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wide_req_valid_i(wreq_valid), .wide_req_ready_o(wreq_ready),
    .wide_req_addr_i(wreq_addr), .wide_req_wen_i(wreq_wen),
    .wide_req_wdata_i(wreq_wdata), .wide_req_be_i(wreq_be),
    .wide_rsp_valid_o(wrsp_valid), .wide_rsp_ready_i(wrsp_ready),
    .wide_rsp_rdata_o(wrsp_rdata),
    .lane_req_valid_o(lreq_valid), .lane_req_ready_i(lreq_ready),
    .lane_req_addr_o(lreq_addr), .lane_req_wen_o(lreq_wen),
    .lane_req_wdata_o(lreq_wdata), .lane_req_be_o(lreq_be),
    .lane_rsp_valid_i(lrsp_valid), .lane_rsp_ready_o(lrsp_ready),
    .lane_rsp_rdata_i(lrsp_rdata), .busy_o(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a lane request slice waits in its lane queue until that
  // lane grants it; a lane response waits in its lane queue until every lane
  // has one, then all are delivered together as one wide response.
  typedef struct {
    logic [AW-1:0] addr;
    logic          wen;
    logic [NW-1:0] wdata;
    logic [NB-1:0] be;
  } lane_t;

  lane_t         pend_q [NP][$];
  logic [NW-1:0] rsp_q  [NP][$];
  int            credits = 0;

  function automatic lane_t wide_slice(input int i);
    lane_t s;
    s.addr  = wreq_addr;
    s.wen   = wreq_wen;
    s.wdata = wreq_wdata[i*NW +: NW];
    s.be    = wreq_be[i*NB +: NB];
    return s;
  endfunction

  always @(negedge clk) begin : cmp
    bit            any_pend, all_rsp, exp_wready, req_hs, rsp_hs;
    logic [NP-1:0] exp_lvalid, exp_lrsp_ready;
    logic [WW-1:0] exp_rdata;
    lane_t         e;
    if (!rst_n) begin
      chk("rst_lane_valid", lreq_valid, 0);
      chk("rst_wide_ready", wreq_ready, 0);
      chk("rst_rsp_valid", wrsp_valid, 0);
      chk("rst_lane_rsp_ready", lrsp_ready, 0);
      chk("rst_busy", busy, 0);
      for (int i = 0; i < NP; i++) begin
        pend_q[i].delete();
        rsp_q[i].delete();
      end
      credits = 0;
    end else begin
      any_pend = 0;
      all_rsp  = 1;
      for (int i = 0; i < NP; i++) begin
        if (pend_q[i].size() != 0) any_pend = 1;
        if (rsp_q[i].size() == 0) all_rsp = 0;
      end
      exp_wready = (credits < MO) && !any_pend;
      for (int i = 0; i < NP; i++) begin
        exp_lvalid[i]     = (pend_q[i].size() != 0) || (exp_wready && wreq_valid);
        exp_lrsp_ready[i] = rsp_q[i].size() < MO;
        exp_rdata[i*NW +: NW] = all_rsp ? rsp_q[i][0] : '0;
      end
      chk("wide_req_ready", wreq_ready, exp_wready);
      chk("lane_req_valid", lreq_valid, exp_lvalid);
      chk("lane_rsp_ready", lrsp_ready, exp_lrsp_ready);
      chk("wide_rsp_valid", wrsp_valid, all_rsp);
      chk("busy", busy, (credits != 0) || any_pend);
      if (all_rsp) chk("wide_rsp_rdata", wrsp_rdata, exp_rdata);
      for (int i = 0; i < NP; i++) begin
        if (exp_lvalid[i]) begin
          e = (pend_q[i].size() != 0) ? pend_q[i][0] : wide_slice(i);
          chk($sformatf("lane%0d_addr", i),  lreq_addr[i*AW +: AW], e.addr);
          chk($sformatf("lane%0d_wen", i),   lreq_wen[i], e.wen);
          chk($sformatf("lane%0d_wdata", i), lreq_wdata[i*NW +: NW], e.wdata);
          chk($sformatf("lane%0d_be", i),    lreq_be[i*NB +: NB], e.be);
        end
      end
      // advance the model to what the coming clock edge does
      req_hs = wreq_valid && exp_wready;
      rsp_hs = all_rsp && wrsp_ready;
      for (int i = 0; i < NP; i++) begin
        if (req_hs) begin
          if (!lreq_ready[i]) pend_q[i].push_back(wide_slice(i));
        end else if (pend_q[i].size() != 0 && lreq_ready[i]) begin
          void'(pend_q[i].pop_front());
        end
        if (rsp_hs) void'(rsp_q[i].pop_front());
        if (lrsp_valid[i] && exp_lrsp_ready[i]) rsp_q[i].push_back(lrsp_rdata[i*NW +: NW]);
      end
      credits = credits + int'(req_hs) - int'(rsp_hs);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [WW-1:0] X1 = 128'h11000003_11000002_11000001_11000000;
  localparam logic [WW-1:0] X2 = 128'h22000003_22000002_22000001_22000000;
  localparam logic [WW-1:0] X3 = 128'h33000003_33000002_33000001_33000000;
  localparam logic [WW-1:0] R1 = 128'hD0000003_D0000002_D0000001_D0000000;

  initial begin
    rst_n = 0; wreq_valid = 0; wreq_addr = 0; wreq_wen = 0; wreq_wdata = 0;
    wreq_be = 0; wrsp_ready = 1; lreq_ready = '1; lrsp_valid = 0; lrsp_rdata = 0;
    repeat (3) tick();
    #1;
    chk("lit_rst_lane_valid", lreq_valid, 0);
    chk("lit_rst_busy", busy, 0);
    tick(); rst_n = 1;
    tick();

    // all lanes ready, read 0x100
    tick(); wreq_valid = 1; wreq_addr = 32'h100; wreq_wen = 0; wreq_be = '1; #1;
    chk("lit_s1_lane_valid", lreq_valid, 4'hF);
    chk("lit_s1_addr", lreq_addr, {4{32'h100}});
    chk("lit_s1_wready", wreq_ready, 1);
    tick(); wreq_valid = 0; lrsp_valid = 4'hF; lrsp_rdata = R1; #1;
    chk("lit_s1_busy", busy, 1);
    tick(); lrsp_valid = 0; #1;
    chk("lit_s1_rsp_valid", wrsp_valid, 1);
    chk("lit_s1_rdata", wrsp_rdata, R1);
    tick(); #1;
    chk("lit_s1_idle", busy, 0);

    // write with lane 2 stalled for 3 cycles, skewed responses
    tick(); wreq_valid = 1; wreq_wen = 1; wreq_addr = 32'h200;
    wreq_wdata = 128'h33330000_22220000_11110000_00000000; lreq_ready = 4'b1011; #1;
    chk("lit_s2_c0_valid", lreq_valid, 4'hF);
    chk("lit_s2_c0_wready", wreq_ready, 1);
    tick(); wreq_valid = 0; wreq_wdata = '0; #1;
    chk("lit_s2_c1_valid", lreq_valid, 4'b0100);
    chk("lit_s2_c1_wdata2", lreq_wdata[64 +: 32], 32'h22220000);
    chk("lit_s2_c1_wready", wreq_ready, 0);
    chk("lit_s2_c1_busy", busy, 1);
    lrsp_rdata = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    tick(); lrsp_valid = 4'b0001; #1;
    chk("lit_s2_c2_wdata2", lreq_wdata[64 +: 32], 32'h22220000);
    tick(); lreq_ready = 4'hF; lrsp_valid = 4'b0100; #1;
    chk("lit_s2_c3_valid", lreq_valid, 4'b0100);
    chk("lit_s2_c3_wready", wreq_ready, 0);
    tick(); lrsp_valid = 4'b1000; #1;
    chk("lit_s2_c4_wready", wreq_ready, 1);
    tick(); lrsp_valid = 4'b0010; #1;
    chk("lit_s2_c5_rsp_valid", wrsp_valid, 0);
    tick(); lrsp_valid = 0; #1;
    chk("lit_s2_c6_rsp_valid", wrsp_valid, 1);
    chk("lit_s2_c6_rdata", wrsp_rdata, 128'h000000A3_000000A2_000000A1_000000A0);
    tick(); #1;
    chk("lit_s2_c7_busy", busy, 0);

    // three back-to-back reads against two credits, then back-pressured responses
    tick(); wreq_valid = 1; wreq_wen = 0; wreq_addr = 32'h300; #1;
    chk("lit_s4_c0_wready", wreq_ready, 1);
    tick(); wreq_addr = 32'h340; #1;
    chk("lit_s4_c1_wready", wreq_ready, 1);
    tick(); wreq_addr = 32'h380; #1;
    chk("lit_s4_c2_wready", wreq_ready, 0);
    chk("lit_s4_c2_valid", lreq_valid, 0);
    tick(); lrsp_valid = 4'hF; lrsp_rdata = X1; #1;
    chk("lit_s4_c3_wready", wreq_ready, 0);
    tick(); lrsp_valid = 0; #1;
    chk("lit_s4_c4_rdata", wrsp_rdata, X1);
    chk("lit_s4_c4_wready", wreq_ready, 0);
    tick(); #1;
    chk("lit_s4_c5_wready", wreq_ready, 1);
    tick(); wreq_valid = 0; lrsp_valid = 4'hF; lrsp_rdata = X2;
    tick(); wrsp_ready = 0; lrsp_rdata = X3; #1;
    chk("lit_s5_c7_rdata", wrsp_rdata, X2);
    tick(); lrsp_valid = 0; #1;
    chk("lit_s5_full", lrsp_ready, 4'h0);
    chk("lit_s5_c8_rdata", wrsp_rdata, X2);
    tick(); #1;
    chk("lit_s5_c9_rdata", wrsp_rdata, X2);
    tick(); #1;
    chk("lit_s5_c10_rdata", wrsp_rdata, X2);
    tick(); wrsp_ready = 1; #1;
    chk("lit_s5_c11_rdata", wrsp_rdata, X2);
    tick(); #1;
    chk("lit_s5_c12_rdata", wrsp_rdata, X3);
    chk("lit_s5_c12_lrsp_ready", lrsp_ready, 4'hF);
    tick(); #1;
    chk("lit_s5_c13_busy", busy, 0);

    // reset while a lane is still pending
    tick(); wreq_valid = 1; wreq_addr = 32'h400; lreq_ready = 4'b1101; #1;
    chk("lit_s6_c0_wready", wreq_ready, 1);
    tick(); wreq_valid = 0; lrsp_valid = 4'hF; lrsp_rdata = X1; #1;
    chk("lit_s6_c1_valid", lreq_valid, 4'b0010);
    tick(); rst_n = 0; lrsp_valid = 0; lreq_ready = 4'hF; #1;
    chk("lit_s6_rst_valid", lreq_valid, 0);
    tick(); rst_n = 1; #1;
    chk("lit_s6_valid", lreq_valid, 0);
    chk("lit_s6_busy", busy, 0);
    chk("lit_s6_rsp_valid", wrsp_valid, 0);
    chk("lit_s6_wready", wreq_ready, 1);
    tick(); wreq_valid = 1; wreq_addr = 32'h500; #1;
    chk("lit_s6_acc1", wreq_ready, 1);
    tick(); #1;
    chk("lit_s6_acc2", wreq_ready, 1);
    tick(); #1;
    chk("lit_s6_acc3", wreq_ready, 0);
    wreq_valid = 0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
